// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus for sram_arbiter. The arbiter takes the slave view;
// requesters plus the SRAM macro (or a bench standing in for them) take the master view.
interface sram_arbiter_if #(
   parameter int NUM_REQ  = 2,
   parameter int DATASIZE = 32,
   parameter int ADDRSIZE = 10
);
   logic [NUM_REQ-1:0]          req;
   logic [NUM_REQ-1:0]          req_we;
   logic [NUM_REQ*ADDRSIZE-1:0] req_addr;
   logic [NUM_REQ*DATASIZE-1:0] req_wdata;
   logic [NUM_REQ-1:0]          gnt;
   logic [NUM_REQ-1:0]          rsp_valid;
   logic [DATASIZE-1:0]         rsp_rdata;
   logic                        rsp_err;
   logic                        sram_cen;
   logic                        sram_wen;
   logic [ADDRSIZE-1:0]         sram_addr;
   logic [DATASIZE-1:0]         sram_wdata;
   logic                        sram_wvalid;
   logic [DATASIZE-1:0]         sram_rdata;
   logic                        sram_out_valid;

   modport slave (
      input  req, req_we, req_addr, req_wdata, sram_rdata, sram_out_valid,
      output gnt, rsp_valid, rsp_rdata, rsp_err,
             sram_cen, sram_wen, sram_addr, sram_wdata, sram_wvalid
   );

   modport master (
      output req, req_we, req_addr, req_wdata, sram_rdata, sram_out_valid,
      input  gnt, rsp_valid, rsp_rdata, rsp_err,
             sram_cen, sram_wen, sram_addr, sram_wdata, sram_wvalid
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM: IDLE grants, CMD issues, ACC completes.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sram_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int DATASIZE = 32,
   parameter int ADDRSIZE = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   sram_arbiter_if.slave bus
);
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, CMD, ACC} state_t;

   state_t                              state_q, state_d;
   logic [IDXW-1:0]                     idx_q, idx_d;
   logic                                we_q, we_d;
   logic [ADDRSIZE-1:0]                 addr_q, addr_d;
   logic [DATASIZE-1:0]                 wdata_q, wdata_d;
   logic [NUM_REQ-1:0]                  rsp_valid_q, rsp_valid_d;
   logic [DATASIZE-1:0]                 rsp_rdata_q, rsp_rdata_d;
   logic                                rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0][ADDRSIZE-1:0]    addr_arr;
   logic [NUM_REQ-1:0][DATASIZE-1:0]    wdata_arr;
   logic [IDXW-1:0]                     win_idx;
   logic [NUM_REQ-1:0]                  win_oh;

   logic                                cen, wen, wvalid;
   logic [ADDRSIZE-1:0]                 s_addr;
   logic [DATASIZE-1:0]                 s_wdata;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = bus.req_addr[g*ADDRSIZE +: ADDRSIZE];
      assign wdata_arr[g] = bus.req_wdata[g*DATASIZE +: DATASIZE];
   end

`ifdef SRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      win_idx = '0;
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (bus.req[IDXW'(i)]) win_idx = IDXW'(i);
   end
`else
   logic [IDXW-1:0] last_gnt_q, last_gnt_d;

   // Search starts one past the last winner and wraps.
   always_comb begin
      logic found;
      int   j;
      found   = 1'b0;
      j       = 0;
      win_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(last_gnt_q) + k) % NUM_REQ;
         if (!found && bus.req[IDXW'(j)]) begin
            found   = 1'b1;
            win_idx = IDXW'(j);
         end
      end
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (state_q == IDLE && |bus.req) last_gnt_d = win_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_gnt_q <= IDXW'(NUM_REQ-1);
      else        last_gnt_q <= last_gnt_d;
   end
`endif

   always_comb begin
      win_oh = '0;
      if (|bus.req) win_oh[win_idx] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      cen         = 1'b1;
      wen         = 1'b1;
      wvalid      = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = CMD;
               idx_d   = win_idx;
               we_d    = bus.req_we[win_idx];
               addr_d  = addr_arr[win_idx];
               wdata_d = wdata_arr[win_idx];
            end
         end
         CMD: begin
            cen     = 1'b0;
            wen     = ~we_q;
            s_addr  = addr_q;
            s_wdata = wdata_q;
            state_d = ACC;
         end
         ACC: begin
            s_addr               = addr_q;
            s_wdata              = wdata_q;
            wvalid               = we_q;
            state_d              = IDLE;
            rsp_valid_d[idx_q]   = 1'b1;
            // A read with no out_valid from the macro is reported, not retried.
            if (!we_q) begin
               if (bus.sram_out_valid) rsp_rdata_d = bus.sram_rdata;
               else                    rsp_err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.gnt         = (state_q == IDLE) ? win_oh : '0;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.sram_cen    = cen;
   assign bus.sram_wen    = wen;
   assign bus.sram_addr   = s_addr;
   assign bus.sram_wdata  = s_wdata;
   assign bus.sram_wvalid = wvalid;
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: a transaction-level model predicts grants, the SRAM pin
// sequence and responses; a behavioural SRAM array answers the DUT's commands.
module tb_sram_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_if #(.NUM_REQ(N), .DATASIZE(DW), .ADDRSIZE(AW)) bus ();
   sram_arbiter #(.NUM_REQ(N), .DATASIZE(DW), .ADDRSIZE(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // staged stimulus, applied just after each rising edge
   logic          stg_req   [N];
   logic          stg_we    [N];
   logic [AW-1:0] stg_addr  [N];
   logic [DW-1:0] stg_wdata [N];
   logic          stg_ovalid;
   logic [DW-1:0] stg_rdata;
   logic          err_next;

   // reference model
   logic [DW-1:0] mem [1024];
   int            cyc, gcyc, ptr, t_idx;
   bit            busy, t_we, acc_ov;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, acc_rd, last_rdata;
   bit            last_err;
   int            order[$];

   function automatic int winner(input logic [N-1:0] r, input int p);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      busy = 0; ptr = N - 1; err_next = 0; stg_ovalid = 0; stg_rdata = '0;
      for (int i = 0; i < N; i++) begin
         stg_req[i] = 0; stg_we[i] = 0; stg_addr[i] = '0; stg_wdata[i] = '0;
      end
      bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.sram_out_valid = 1'b0; bus.sram_rdata = '0;
   endtask

   task automatic stage(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      stg_req[i] = 1; stg_we[i] = we; stg_addr[i] = a; stg_wdata[i] = d;
   endtask

   task automatic check_cycle();
      int d, w;
      logic [N-1:0] eg, er;
      logic ecen, ewen, ewv;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewd;
      d = busy ? cyc - gcyc : 99;
      er = '0;
      if (d == 3) begin
         er[t_idx] = 1'b1;
         chk("rsp_valid", bus.rsp_valid, er);
         chk("rsp_rdata", bus.rsp_rdata, (!t_we && acc_ov) ? acc_rd : '0);
         chk("rsp_err", bus.rsp_err, !t_we && !acc_ov);
         last_rdata = bus.rsp_rdata; last_err = bus.rsp_err;
         busy = 0;
      end else chk("rsp_valid_idle", bus.rsp_valid, er);
      ecen = 1; ewen = 1; ewv = 0; eaddr = '0; ewd = '0;
      if (busy && d == 1) begin ecen = 0; ewen = !t_we; eaddr = t_addr; ewd = t_wdata; end
      if (busy && d == 2) begin
         eaddr = t_addr; ewd = t_wdata; ewv = t_we;
         acc_ov = bus.sram_out_valid; acc_rd = bus.sram_rdata;
      end
      chk("sram_cen", bus.sram_cen, ecen);
      chk("sram_wen", bus.sram_wen, ewen);
      chk("sram_wvalid", bus.sram_wvalid, ewv);
      chk("sram_addr", bus.sram_addr, eaddr);
      chk("sram_wdata", bus.sram_wdata, ewd);
      w = (busy && (d == 1 || d == 2)) ? -1 : winner(bus.req, ptr);
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", bus.gnt, eg);
      if (w >= 0) begin
         busy = 1; gcyc = cyc; t_idx = w; ptr = w;
         t_we = bus.req_we[w];
         t_addr = bus.req_addr[w*AW +: AW];
         t_wdata = bus.req_wdata[w*DW +: DW];
         order.push_back(w);
         stg_req[w] = 0;
      end
      // behavioural SRAM reacting to the DUT's pins
      stg_ovalid = 0; stg_rdata = $urandom;
      if (!bus.sram_cen && bus.sram_wen) begin
         stg_ovalid = !err_next; stg_rdata = mem[bus.sram_addr]; err_next = 0;
      end
      if (bus.sram_wvalid) mem[bus.sram_addr] = bus.sram_wdata;
   endtask

   task automatic cycle();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         bus.req[i] = stg_req[i]; bus.req_we[i] = stg_we[i];
         bus.req_addr[i*AW +: AW] = stg_addr[i];
         bus.req_wdata[i*DW +: DW] = stg_wdata[i];
      end
      bus.sram_out_valid = stg_ovalid; bus.sram_rdata = stg_rdata;
      @(negedge clk);
      check_cycle();
      cyc++;
   endtask

   task automatic run_until_done();
      bit pend;
      for (int t = 0; t < 40; t++) begin
         cycle();
         pend = 0;
         for (int i = 0; i < N; i++) if (stg_req[i]) pend = 1;
         if (!busy && !pend) return;
      end
      chk("drain_timeout", 1, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0; model_reset();
      @(negedge clk); rst_n = 1'b1;
   endtask

   initial begin
      int base;
      for (int a = 0; a < 1024; a++) mem[a] = '0;
      cyc = 0; model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_cen", bus.sram_cen, 1);
      chk("rst_wen", bus.sram_wen, 1);
      chk("rst_wvalid", bus.sram_wvalid, 0);
      chk("rst_addr", bus.sram_addr, 0);
      chk("rst_wdata", bus.sram_wdata, 0);
      @(negedge clk); rst_n = 1'b1;

      // write then read back
      stage(0, 1, 10'h005, 32'hDEADBEEF); run_until_done();
      stage(0, 0, 10'h005, 32'h0);        run_until_done();
      chk("wr_rd_data", last_rdata, 32'hDEADBEEF);
      chk("wr_rd_err", last_err, 0);

      // contention from reset
      pulse_reset(); order.delete();
      for (int t = 0; t < 40 && order.size() < 4; t++) begin
         for (int i = 0; i < N; i++)
            if (!stg_req[i]) stage(i, 0, AW'($urandom_range(15)), $urandom);
         cycle();
      end
      for (int i = 0; i < N; i++) stg_req[i] = 0;
      run_until_done();
      chk("contention_cnt", order.size() >= 4, 1);
      for (int k = 0; k < 4 && k < order.size(); k++)
`ifdef SRAM_ARB_FIXED_PRIO_EN
         chk("contention_order", order[k], 0);
`else
         chk("contention_order", order[k], k % 2);
`endif

      // read without out_valid
      err_next = 1; stage(0, 0, 10'h3FF, 32'h0); run_until_done();
      chk("rderr_rdata", last_rdata, 0);
      chk("rderr_err", last_err, 1);

      // reset during the CMD phase of a read
      stage(0, 1, 10'h020, 32'h1234_5678); run_until_done();
      stage(0, 0, 10'h010, 32'h0);
      for (int t = 0; t < 10 && !busy; t++) cycle();
      cycle();
      chk("mid_cmd_cen", bus.sram_cen, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cen", bus.sram_cen, 1);
      chk("mid_rst_wen", bus.sram_wen, 1);
      chk("mid_rst_addr", bus.sram_addr, 0);
      model_reset();
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_rsp", bus.rsp_valid, 0);
      end
      rst_n = 1'b1;
      base = order.size();
      stage(0, 0, 10'h010, 32'h0); stage(1, 0, 10'h011, 32'h0);
      for (int t = 0; t < 10 && order.size() == base; t++) cycle();
      chk("post_rst_first", (order.size() > base) ? order[base] : -1, 0);
      run_until_done();

      // random traffic
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++)
            if (!stg_req[i] && $urandom_range(2) == 0)
               stage(i, $urandom_range(1), ($urandom_range(7) == 0) ? 10'h3FF : AW'($urandom_range(15)), $urandom);
         if (!err_next) err_next = ($urandom_range(7) == 0);
         cycle();
      end
      run_until_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
